// File: rtl/madnes_video_pkg.sv
`default_nettype none
// ============================================================================
// Module   : madnes_video_pkg
// Brief    : Shared video constants, pixel/line types and scanout FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package madnes_video_pkg;

    localparam int DISPLAY_WIDTH     = 600;
    localparam int DISPLAY_HEIGHT    = 480;
    localparam int COLOR_DEPTH       = 8;
    localparam int LINE_NUMBER_WIDTH = $clog2(DISPLAY_WIDTH);

    // One pixel: three colour channels
    typedef logic [2:0][COLOR_DEPTH-1:0] rgb_t;

    // One full active line of pixels
    typedef logic [DISPLAY_WIDTH-1:0][2:0][COLOR_DEPTH-1:0] line_t;

    // EMPTY: back buffer free; FULL: back buffer holds a line not yet shown
    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } scanout_state_t;

endpackage : madnes_video_pkg
`default_nettype wire

// File: rtl/scanout_pixel_mux.sv
`default_nettype none
// ============================================================================
// Module   : scanout_pixel_mux
// Brief    : Combinational pixel select from the front line, background
//            substitution for transparent (all-zero) pixels and blanking
//            outside the active area.
// Revision : 1.0 - initial release
// ============================================================================
module scanout_pixel_mux #(
    parameter int DISPLAY_WIDTH     = 600,
    parameter int DISPLAY_HEIGHT    = 480,
    parameter int COLOR_DEPTH       = 8,
    parameter int LINE_NUMBER_WIDTH = 10
) (
    input  logic [DISPLAY_WIDTH-1:0][2:0][COLOR_DEPTH-1:0] front_i,
    input  logic [LINE_NUMBER_WIDTH-1:0]                   sx_i,
    input  logic [LINE_NUMBER_WIDTH-1:0]                   sy_i,
    input  logic [2:0][COLOR_DEPTH-1:0]                    bg_color_i,
    output logic [2:0][COLOR_DEPTH-1:0]                    pix_o,
    output logic                                           pix_valid_o
);

    localparam logic [LINE_NUMBER_WIDTH-1:0] c_width  = LINE_NUMBER_WIDTH'(DISPLAY_WIDTH);
    localparam logic [LINE_NUMBER_WIDTH-1:0] c_height = LINE_NUMBER_WIDTH'(DISPLAY_HEIGHT);

    logic [2:0][COLOR_DEPTH-1:0] w_sel;

    // Pick front[sx] inside the active area; zero pixels show the background
    always_comb begin
        pix_o       = '0;
        pix_valid_o = 1'b0;
        w_sel       = '0;
        if ((sx_i < c_width) && (sy_i < c_height)) begin
            w_sel       = front_i[sx_i];
            pix_valid_o = 1'b1;
            pix_o       = (w_sel == '0) ? bg_color_i : w_sel;
        end
    end

endmodule : scanout_pixel_mux
`default_nettype wire

// File: rtl/line_scanout.sv
`default_nettype none
// ============================================================================
// Module   : line_scanout
// Brief    : Double-buffered line scanout. A drawn line is captured into the
//            back buffer on line_done and promoted to the front buffer at the
//            end of the active line (sx == DISPLAY_WIDTH). Pixels are read
//            from the front buffer with one cycle of latency.
// Options  : LINE_SCANOUT_UNDERRUN_COUNT_EN adds an 8-bit saturating
//            underrun_count output.
// Revision : 1.0 - initial release
// ============================================================================
module line_scanout #(
    parameter int DISPLAY_WIDTH     = madnes_video_pkg::DISPLAY_WIDTH,
    parameter int DISPLAY_HEIGHT    = madnes_video_pkg::DISPLAY_HEIGHT,
    parameter int COLOR_DEPTH       = madnes_video_pkg::COLOR_DEPTH,
    parameter int LINE_NUMBER_WIDTH = $clog2(DISPLAY_WIDTH)
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           line_done,
    input  logic [DISPLAY_WIDTH-1:0][2:0][COLOR_DEPTH-1:0] line_buffer,
    input  logic [LINE_NUMBER_WIDTH-1:0]                   line_number,
    input  logic [LINE_NUMBER_WIDTH-1:0]                   sx,
    input  logic [LINE_NUMBER_WIDTH-1:0]                   sy,
    input  logic [2:0][COLOR_DEPTH-1:0]                    bg_color,
    output logic [2:0][COLOR_DEPTH-1:0]                    pix,
    output logic                                           pix_valid,
    output logic                                           line_req,
    output logic                                           underrun
`ifdef LINE_SCANOUT_UNDERRUN_COUNT_EN
    ,
    output logic [7:0]                                     underrun_count
`endif
);

    import madnes_video_pkg::*;

    localparam logic [LINE_NUMBER_WIDTH-1:0] c_swap_x = LINE_NUMBER_WIDTH'(DISPLAY_WIDTH);

    scanout_state_t                                 state_q,     state_d;
    logic [DISPLAY_WIDTH-1:0][2:0][COLOR_DEPTH-1:0] front_q,     front_d;
    logic [DISPLAY_WIDTH-1:0][2:0][COLOR_DEPTH-1:0] back_q,      back_d;
    logic [LINE_NUMBER_WIDTH-1:0]                   front_num_q, front_num_d;
    logic [LINE_NUMBER_WIDTH-1:0]                   back_num_q,  back_num_d;
    logic [2:0][COLOR_DEPTH-1:0]                    pix_q;
    logic                                           pix_valid_q;
    logic                                           line_req_q,  line_req_d;
    logic                                           underrun_q,  underrun_d;

    logic                                           w_swap;
    logic [2:0][COLOR_DEPTH-1:0]                    w_pix;
    logic                                           w_pix_valid;

    // The front line number is kept for observation; display never waits on it
    logic                                           w_unused_front_num;
    assign w_unused_front_num = ^front_num_q;

    assign w_swap = (sx == c_swap_x);

    // Buffer handoff FSM: capture on line_done, promote on swap, flag underrun
    always_comb begin
        state_d     = state_q;
        front_d     = front_q;
        back_d      = back_q;
        front_num_d = front_num_q;
        back_num_d  = back_num_q;
        line_req_d  = w_swap;
        underrun_d  = 1'b0;
        case (state_q)
            EMPTY: begin
                if (w_swap) begin
                    underrun_d = 1'b1;
                end
                if (line_done) begin
                    back_d     = line_buffer;
                    back_num_d = line_number;
                    state_d    = FULL;
                end
            end
            FULL: begin
                if (w_swap) begin
                    front_d     = back_q;
                    front_num_d = back_num_q;
                    state_d     = EMPTY;
                end
                if (line_done) begin
                    back_d     = line_buffer;
                    back_num_d = line_number;
                    state_d    = FULL;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    scanout_pixel_mux #(
        .DISPLAY_WIDTH     (DISPLAY_WIDTH),
        .DISPLAY_HEIGHT    (DISPLAY_HEIGHT),
        .COLOR_DEPTH       (COLOR_DEPTH),
        .LINE_NUMBER_WIDTH (LINE_NUMBER_WIDTH)
    ) u_pixel_mux (
        .front_i     (front_q),
        .sx_i        (sx),
        .sy_i        (sy),
        .bg_color_i  (bg_color),
        .pix_o       (w_pix),
        .pix_valid_o (w_pix_valid)
    );

    // State, buffers and registered pixel/pulse outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= EMPTY;
            front_q     <= '0;
            back_q      <= '0;
            front_num_q <= '0;
            back_num_q  <= '0;
            pix_q       <= '0;
            pix_valid_q <= 1'b0;
            line_req_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            front_q     <= front_d;
            back_q      <= back_d;
            front_num_q <= front_num_d;
            back_num_q  <= back_num_d;
            pix_q       <= w_pix;
            pix_valid_q <= w_pix_valid;
            line_req_q  <= line_req_d;
            underrun_q  <= underrun_d;
        end
    end

    assign pix       = pix_q;
    assign pix_valid = pix_valid_q;
    assign line_req  = line_req_q;
    assign underrun  = underrun_q;

`ifdef LINE_SCANOUT_UNDERRUN_COUNT_EN
    logic [7:0] ur_count_q;

    // Saturating count of underrun pulses, advanced alongside the pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ur_count_q <= 8'd0;
        end else if (underrun_d && (ur_count_q != 8'd255)) begin
            ur_count_q <= ur_count_q + 8'd1;
        end
    end

    assign underrun_count = ur_count_q;
`endif

endmodule : line_scanout
`default_nettype wire

// File: tb/tb_line_scanout.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_scanout
// Brief    : Self-checking bench for line_scanout using a scoreboard queue
//            fed by a small behavioural model of the buffer handoff.
// Options  : LINE_SCANOUT_UNDERRUN_COUNT_EN enables the counter scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_scanout;
    import madnes_video_pkg::*;

    logic                         clk   = 1'b0;
    logic                         reset = 1'b1;
    logic                         line_done = 1'b0;
    line_t                        line_buffer = '0;
    logic [LINE_NUMBER_WIDTH-1:0] line_number = '0;
    logic [LINE_NUMBER_WIDTH-1:0] sx = '0;
    logic [LINE_NUMBER_WIDTH-1:0] sy = '0;
    rgb_t                         bg_color = '0;
    rgb_t                         pix;
    logic                         pix_valid;
    logic                         line_req;
    logic                         underrun;
`ifdef LINE_SCANOUT_UNDERRUN_COUNT_EN
    logic [7:0]                   underrun_count;
`endif

    always #5 clk = ~clk;

    line_scanout dut (
        .clk         (clk),
        .reset       (reset),
        .line_done   (line_done),
        .line_buffer (line_buffer),
        .line_number (line_number),
        .sx          (sx),
        .sy          (sy),
        .bg_color    (bg_color),
        .pix         (pix),
        .pix_valid   (pix_valid),
        .line_req    (line_req),
        .underrun    (underrun)
`ifdef LINE_SCANOUT_UNDERRUN_COUNT_EN
        ,
        .underrun_count (underrun_count)
`endif
    );

    typedef struct {
        string       tag;
        logic [26:0] exp;
    } exp_t;

    exp_t  sb[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    // Staged stimulus, applied to the DUT only at the drive point of a step
    line_t                        lb_next = '0;
    logic [LINE_NUMBER_WIDTH-1:0] ln_next = '0;
    rgb_t                         bg_next = '0;

    // Behavioural model state
    line_t m_front = '0;
    line_t m_back  = '0;
    bit    m_full  = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    function automatic logic [26:0] observed();
        return {pix, pix_valid, underrun, line_req};
    endfunction

    task automatic pop_check();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, {5'b0, observed()}, {5'b0, e.exp});
        end
    endtask

    // One clock of stimulus: check the previous cycle, drive, predict
    task automatic step(input string tag, input int x, input int y, input bit ld);
        bit   swap;
        bit   v;
        bit   ur;
        rgb_t p;
        @(negedge clk);
        pop_check();
        sx          = LINE_NUMBER_WIDTH'(x);
        sy          = LINE_NUMBER_WIDTH'(y);
        line_done   = ld;
        line_buffer = lb_next;
        line_number = ln_next;
        bg_color    = bg_next;
        swap = (x == DISPLAY_WIDTH);
        v    = 1'b0;
        p    = '0;
        if (x < DISPLAY_WIDTH && y < DISPLAY_HEIGHT) begin
            v = 1'b1;
            p = m_front[x];
            if (p == '0) p = bg_next;
        end
        ur = swap && !m_full;
        sb.push_back('{tag, {p, v, ur, swap}});
        if (swap && m_full) m_front = m_back;
        if (swap) m_full = ld;
        else if (ld) m_full = 1'b1;
        if (ld) m_back = lb_next;
    endtask

    task automatic do_reset();
        @(negedge clk);
        pop_check();
        sx        = '0;
        sy        = '0;
        line_done = 1'b0;
        #2 reset = 1'b0;
        #1 check("rst_async", {5'b0, observed()}, 32'd0);
        @(negedge clk);
        check("rst_hold", {5'b0, observed()}, 32'd0);
`ifdef LINE_SCANOUT_UNDERRUN_COUNT_EN
        check("rst_count", {24'b0, underrun_count}, 32'd0);
`endif
        reset   = 1'b1;
        m_front = '0;
        m_back  = '0;
        m_full  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();

        // Nothing drawn: swap underruns, front is all zero with black background
        step("swap_empty", 600, 0, 0);
        step("blank_px", 5, 1, 0);

        // Line with a colour at 5, transparent at 7, colour at last column
        lb_next = '0;
        lb_next[5]   = {8'd10, 8'd20, 8'd30};
        lb_next[599] = {8'd9, 8'd9, 8'd9};
        ln_next = 10'd1;
        step("ld_line1", 100, 1, 1);
        step("swap_full", 600, 1, 0);
        step("px5", 5, 1, 0);
        bg_next = {8'd1, 8'd2, 8'd3};
        step("px7_bg", 7, 1, 0);
        step("px_right", 610, 1, 0);
        step("px_last", 599, 479, 0);
        step("px_below", 5, 480, 0);

        // Newest pending line wins
        lb_next = '0; lb_next[5] = {8'd3, 8'd3, 8'd3}; ln_next = 10'd3;
        step("ld_line3", 0, 2, 1);
        lb_next = '0; lb_next[5] = {8'd4, 8'd4, 8'd4}; ln_next = 10'd4;
        step("ld_line4", 1, 2, 1);
        step("swap_l4", 600, 2, 0);
        step("px5_l4", 5, 3, 0);
        check("front_num", {22'b0, dut.front_num_q}, 32'd4);

        // line_done coinciding with swap while FULL
        lb_next = '0; lb_next[5] = {8'h55, 8'h55, 8'h55}; ln_next = 10'd5;
        step("ld_A", 0, 3, 1);
        lb_next = '0; lb_next[5] = {8'h66, 8'h66, 8'h66}; ln_next = 10'd6;
        step("swap_ld_full", 600, 3, 1);
        step("px5_A", 5, 4, 0);
        step("swap_B", 600, 4, 0);
        step("px5_B", 5, 5, 0);
        step("swap_under", 600, 5, 0);

        // line_done coinciding with swap while EMPTY
        lb_next = '0; lb_next[5] = {8'h77, 8'h01, 8'h02}; ln_next = 10'd7;
        step("swap_ld_empty", 600, 6, 1);
        step("swap_C", 600, 7, 0);
        step("px5_C", 5, 8, 0);

        // Reset discards a pending line
        lb_next = '0; lb_next[5] = {8'h88, 8'h88, 8'h88}; ln_next = 10'd9;
        step("ld_D", 0, 9, 1);
        do_reset();
        step("swap_post_rst", 600, 9, 0);
        step("px5_post_rst", 5, 10, 0);

`ifdef LINE_SCANOUT_UNDERRUN_COUNT_EN
        for (int i = 0; i < 300; i++) step("ur_run", 600, 0, 0);
        step("ur_tail", 0, 0, 0);
        @(negedge clk);
        pop_check();
        check("ur_count_sat", {24'b0, underrun_count}, 32'd255);
        do_reset();
`endif

        step("tail", 0, 0, 0);
        @(negedge clk);
        pop_check();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_line_scanout
`default_nettype wire

// File: doc/line_scanout.md
LINE_SCANOUT -- requirements
Module: line_scanout

Interface
REQ-001 SHALL have parameter DISPLAY_WIDTH, default 600, meaning active pixels per line.
REQ-002 SHALL have parameter DISPLAY_HEIGHT, default 480, meaning active lines per frame.
REQ-003 SHALL have parameter COLOR_DEPTH, default 8, meaning bits per colour channel.
REQ-004 SHALL have parameter LINE_NUMBER_WIDTH, default $clog2(DISPLAY_WIDTH), meaning width of sx, sy and line_number.
REQ-005 SHALL have port clk, input, 1, the single clock; every flop SHALL be clocked on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port line_done, input, 1, pulse from sprite_drawer meaning line_buffer is complete.
REQ-008 SHALL have port line_buffer, input, [DISPLAY_WIDTH-1:0][2:0][COLOR_DEPTH-1:0], the drawn line.
REQ-009 SHALL have port line_number, input, LINE_NUMBER_WIDTH, the line that line_buffer belongs to.
REQ-010 SHALL have ports sx and sy, input, LINE_NUMBER_WIDTH each, the current scan position.
REQ-011 SHALL have port bg_color, input, [2:0][COLOR_DEPTH-1:0], substituted for transparent pixels.
REQ-012 SHALL have port pix, output, [2:0][COLOR_DEPTH-1:0], the registered pixel.
REQ-013 SHALL have port pix_valid, output, 1, high when pix is an active-area pixel.
REQ-014 SHALL have port line_req, output, 1, one-cycle pulse requesting preparation of the next line.
REQ-015 SHALL have port underrun, output, 1, one-cycle pulse when a swap finds no new line.

Function
REQ-016 SHALL hold a front buffer (being displayed) and a back buffer (received), each with a stored line number.
REQ-017 SHALL implement states EMPTY (back buffer free) and FULL (back buffer holds an unshown line).
REQ-018 SHALL define swap_event as the cycle with sx == DISPLAY_WIDTH.
REQ-019 In EMPTY, line_done SHALL capture line_buffer and line_number into the back buffer and move to FULL.
REQ-020 In FULL, swap_event SHALL copy the back buffer to the front buffer and move to EMPTY.
REQ-021 In EMPTY, swap_event SHALL keep the front buffer, pulse underrun and stay in EMPTY.
REQ-022 In FULL, line_done without swap_event SHALL overwrite the back buffer, so the newest line wins, and stay in FULL.
REQ-023 A simultaneous line_done and swap_event in FULL SHALL move the old back buffer to the front, capture the new line into the back buffer and stay in FULL.
REQ-024 A simultaneous line_done and swap_event in EMPTY SHALL pulse underrun, capture the new line into the back buffer and move to FULL.
REQ-025 line_req SHALL pulse on every swap_event, regardless of state.
REQ-026 Pixel latency SHALL be one cycle: pix/pix_valid at cycle t+1 reflect sx/sy at cycle t.
REQ-027 Active area SHALL be sx < DISPLAY_WIDTH and sy < DISPLAY_HEIGHT; outside it, pix SHALL be 0 and pix_valid 0.
REQ-028 Inside the active area, pix SHALL be front[sx], or bg_color if all three channels of front[sx] are zero.
REQ-029 A front line whose stored line number differs from sy SHALL still be displayed; no stall or skip is performed.

Reset
REQ-030 Asserting reset SHALL asynchronously clear the state to EMPTY, clear both buffers and line numbers to 0, and clear pix, pix_valid, line_req and underrun to 0.
REQ-031 Reset mid-line SHALL discard any pending back line; the first swap_event after release SHALL pulse underrun unless line_done arrived first.

Configuration
REQ-032 Macro LINE_SCANOUT_UNDERRUN_COUNT_EN, when defined, SHALL add output underrun_count, 8 bits, incremented on each underrun pulse, saturating at 255, and cleared by reset.
REQ-033 Without that macro, the port and counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-034 Package madnes_video_pkg SHALL hold the DISPLAY_WIDTH/DISPLAY_HEIGHT/COLOR_DEPTH/LINE_NUMBER_WIDTH constants, typedef rgb_t, typedef line_t and enum scanout_state_t {EMPTY, FULL}.
REQ-035 Sub-module scanout_pixel_mux SHALL perform the combinational front[sx] select, bg_color substitution and blanking; the parent registers its output.

Verification
REQ-036 Bench SHALL cover: reset low, then release with no line_done; swap at sx=600 -> underrun=1, line_req=1, pix=0 in the active area.
REQ-037 Bench SHALL cover: line_done with pixel 5 = {10,20,30}, swap, then sx=5, sy=1 -> pix={10,20,30}, pix_valid=1 next cycle.
REQ-038 Bench SHALL cover: pixel 7 = {0,0,0}, bg_color={1,2,3}, sx=7 -> pix={1,2,3}; sx=610 -> pix=0, pix_valid=0.
REQ-039 Bench SHALL cover: two line_done pulses (lines 3 then 4) before a swap -> front line number 4 and line 4 pixels shown.
REQ-040 Bench SHALL cover: line_done coincident with swap_event in FULL -> old back line shown, new line pending, no underrun.
REQ-041 Bench SHALL cover: with the macro defined, 300 consecutive underruns -> underrun_count=255; reset -> 0.
